operand_pair_alu: RTL and testbench
===================================

// Module: operand_pair_alu
// PURPOSE
//  Sits directly downstream of the class-based Driver: it consumes the (a,b) operand pairs
//  that the Driver pushes through tb_interface. Each pair gets an opcode. The pair passes
//  through a 2-stage in-order pipeline into an output FIFO, and the result leaves the block
//  with a sequence tag so a monitor/scoreboard can check it against the stimulus.
// PARAMETERS
//  DATA_W     4   operand width; result width is 2*DATA_W
//  OUT_DEPTH  4   output FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1         single clock, all state on posedge
//  reset        in   1         synchronous, active-high
//  in_valid     in   1         operand pair valid
//  in_ready     out  1         block can accept a pair this cycle
//  in_a         in   DATA_W    operand a (unsigned)
//  in_b         in   DATA_W    operand b (unsigned)
//  in_op        in   2         00 ADD, 01 SUB, 10 MUL, 11 MAX
//  out_valid    out  1         result valid
//  out_ready    in   1         consumer accepts the result
//  out_result   out  2*DATA_W  result
//  out_ovf      out  1         ADD carry out of DATA_W bits / SUB borrow (a<b); 0 for MUL and MAX
//  out_tag      out  8         sequence number of the originating input transaction
//  txn_count    out  16        completed output handshakes, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (sampled at posedge): the pipeline valids, FIFO pointers and count, tag counter
//    and txn_count all clear. While reset is high: in_ready=0, out_valid=0.
//    out_result, out_ovf and out_tag read 0 while out_valid=0.
//  - Reset mid-operation discards every in-flight and buffered result; no partial output appears.
//  - Input handshake: a pair is accepted on the posedge where in_valid && in_ready.
//    in_a, in_b and in_op are ignored when in_valid=0.
//  - Credit rule: in_ready = !reset && (fifo_count + s1_valid + s2_valid) < OUT_DEPTH.
//    in_ready is computed from registers only; there is no combinational path from out_ready.
//  - S1 registers a, b, op and tag. S2 computes the result and writes the FIFO.
//    Latency: a pair accepted at edge N gives out_valid=1 in the cycle after edge N+2 when
//    the FIFO was empty. Full throughput is 1 pair/cycle while out_ready=1.
//  - Arithmetic: operands are zero-extended to 2*DATA_W.
//    ADD: a+b.  SUB: (a-b) mod 2^(2*DATA_W).  MUL: a*b, full width.  MAX: larger of a and b.
//  - Tag: an 8-bit counter, incremented on each input handshake, wrapping 255->0.
//    Results leave strictly in acceptance order.
//  - Output handshake: pop when out_valid && out_ready. out_result, out_ovf and out_tag
//    hold stable while out_valid && !out_ready.
//  - FIFO: simultaneous push and pop is legal at any occupancy, including full (the credit
//    rule guarantees no push into a full FIFO unless a pop happens in the same cycle) and
//    empty (no bypass; output arrives the next cycle).
//  - txn_count increments on each output handshake and stops at 16'hFFFF.
// STRUCTURE
//  - alu_pkg: typedef enum logic[1:0] op_e {OP_ADD, OP_SUB, OP_MUL, OP_MAX};
//    typedef struct result_t {result, ovf, tag}; localparam TAG_W=8.
//  - Sub-module sync_fifo #(WIDTH, DEPTH): ptr-based, count output, no bypass.
//    The top level holds the pipeline, credit logic and counters.
// TESTING
//  1 ADD 3,5 after reset, out_ready=1 -> out_result=8'h08, ovf=0, tag=0, 3 cycles after accept
//  2 SUB 1,2; MUL 9,6; MAX 8,7; ADD 9,8 back-to-back -> 8'hFF ovf=1; 8'h36 ovf=0;
//    8'h08 ovf=0; 8'h11 ovf=1; tags 0..3 in order
//  3 out_ready=0, offer 6 pairs -> exactly 4 accepted, in_ready=0 afterwards; raise out_ready
//    -> tags 0..3 drain with stable data, then the remaining 2 are accepted
//  4 Steady stream with out_ready=1 -> one result per cycle, no bubbles, txn_count matches
//    the handshakes
//  5 Reset asserted with 3 results buffered -> next cycle out_valid=0, in_ready=0,
//    txn_count=0; the first post-reset pair gets tag 0
//  6 Stream 257 pairs -> tag sequence ...,254,255,0; no lost or duplicated results

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the operand-pair ALU: opcode encoding, result record and tag width.
package alu_pkg;

  localparam int unsigned TAG_W      = 8;
  localparam int unsigned DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAX = 2'b11
  } op_e;

  // Result record at the default operand width; the top builds the same layout for any DATA_W.
  typedef struct packed {
    logic [2*DEF_DATA_W-1:0] result;
    logic                    ovf;
    logic [TAG_W-1:0]        tag;
  } result_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO with occupancy count; no write-to-read bypass.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/operand_pair_alu.sv
// Two-stage in-order ALU pipeline feeding a credit-managed output FIFO; results carry a
// sequence tag and a saturating handshake counter tracks completed outputs.
module operand_pair_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [1:0]          in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_result,
  output logic                out_ovf,
  output logic [TAG_W-1:0]    out_tag,
  output logic [15:0]         txn_count
);

  localparam int unsigned ResW = 2 * DATA_W;
  localparam int unsigned CntW = $clog2(OUT_DEPTH) + 1;

  typedef struct packed {
    logic [ResW-1:0]  result;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  // Stage 1: registered operands
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  op_e               s1_op_q, s1_op_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  // Stage 2: registered result awaiting FIFO write
  logic              s2_valid_q, s2_valid_d;
  entry_t            s2_entry_q, s2_entry_d;

  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [15:0]       txn_q, txn_d;

  logic [ResW-1:0]   a_ext, b_ext;
  logic [ResW-1:0]   alu_result;
  logic              alu_ovf;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty;
  logic [EntryW-1:0] fifo_rdata;
  entry_t            head;
  logic [CntW:0]     inflight;
  logic              accept;
  logic              pop;

  // Every result already committed to the pipeline owns a FIFO slot, so S2 never stalls.
  assign inflight = {1'b0, fifo_count}
                  + {{CntW{1'b0}}, s1_valid_q}
                  + {{CntW{1'b0}}, s2_valid_q};
  assign in_ready = !reset && (inflight < (CntW + 1)'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;

  assign out_valid = !reset && !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    a_ext      = {{DATA_W{1'b0}}, s1_a_q};
    b_ext      = {{DATA_W{1'b0}}, s1_b_q};
    alu_result = '0;
    alu_ovf    = 1'b0;
    unique case (s1_op_q)
      OP_ADD: begin
        alu_result = a_ext + b_ext;
        alu_ovf    = alu_result[DATA_W];
      end
      OP_SUB: begin
        alu_result = a_ext - b_ext;
        alu_ovf    = (s1_a_q < s1_b_q);
      end
      OP_MUL: begin
        alu_result = a_ext * b_ext;
      end
      OP_MAX: begin
        alu_result = (s1_a_q >= s1_b_q) ? a_ext : b_ext;
      end
      default: begin
        alu_result = '0;
      end
    endcase
  end

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    tag_d      = tag_q;
    if (accept) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_op_d  = op_e'(in_op);
      s1_tag_d = tag_q;
      tag_d    = tag_q + 1'b1;
    end

    s2_valid_d = s1_valid_q;
    s2_entry_d = s2_entry_q;
    if (s1_valid_q) begin
      s2_entry_d.result = alu_result;
      s2_entry_d.ovf    = alu_ovf;
      s2_entry_d.tag    = s1_tag_q;
    end

    txn_d = pop ? sat_inc16(txn_q) : txn_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      tag_q      <= '0;
      txn_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      tag_q      <= tag_d;
      txn_q      <= txn_d;
    end
  end

  // Datapath registers are qualified by the valids and need no reset.
  always_ff @(posedge clk) begin
    s1_a_q     <= s1_a_d;
    s1_b_q     <= s1_b_d;
    s1_op_q    <= s1_op_d;
    s1_tag_q   <= s1_tag_d;
    s2_entry_q <= s2_entry_d;
  end

  sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (s2_valid_q),
    .wdata_i (s2_entry_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign head       = entry_t'(fifo_rdata);
  assign out_result = out_valid ? head.result : '0;
  assign out_ovf    = out_valid ? head.ovf : 1'b0;
  assign out_tag    = out_valid ? head.tag : '0;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_operand_pair_alu.sv
// Randomised and directed bench for operand_pair_alu with a queue-based reference model.
module tb_operand_pair_alu;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a, in_b;
  logic [1:0]      in_op;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_result;
  logic            out_ovf;
  logic [7:0]      out_tag;
  logic [15:0]     txn_count;

  operand_pair_alu #(
    .DATA_W    (DW),
    .OUT_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_tag    (out_tag),
    .txn_count  (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int result;
    int ovf;
    int tag;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t got_q[$];
  int   tag_m = 0;
  int   hs_m  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int op, input int tag);
    exp_t e;
    int   mask;
    mask  = (1 << (2 * DW)) - 1;
    e.tag = tag;
    e.ovf = 0;
    case (op)
      0: begin
        e.result = a + b;
        e.ovf    = (a + b >= (1 << DW)) ? 1 : 0;
      end
      1: begin
        e.result = (a - b) & mask;
        e.ovf    = (a < b) ? 1 : 0;
      end
      2:       e.result = a * b;
      default: e.result = (a > b) ? a : b;
    endcase
    return e;
  endfunction

  // Scoreboard: everything sampled at negedge takes effect at the following posedge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      exp_q.delete();
      tag_m = 0;
      hs_m  = 0;
    end else begin
      check("txn_count", 32'(txn_count), 32'(hs_m));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(in_a), int'(in_b), int'(in_op), tag_m));
        tag_m = (tag_m + 1) % 256;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check("out_result", 32'(out_result), 32'(exp_q[0].result));
          check("out_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
          check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
        end
        if (out_ready) begin
          got_q.push_back('{int'(out_result), int'(out_ovf), int'(out_tag)});
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs_m = (hs_m < 16'hFFFF) ? hs_m + 1 : hs_m;
        end
      end else begin
        check("idle_zero", 32'({out_result, out_ovf, out_tag}), 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op);
    int c    = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    while (!done && c < 100) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      c++;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain();
    int c = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_stream(input int n, input int pv, input int pr);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < n * 20 + 100) begin
      in_valid  = ($urandom_range(99) < pv);
      in_a      = DW'($urandom_range(15));
      in_b      = DW'($urandom_range(15));
      in_op     = 2'($urandom_range(3));
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_accepts", 32'(acc), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pa[6] = '{1, 2, 3, 4, 5, 6};
    int pb[6] = '{7, 3, 2, 9, 5, 1};
    int idx;
    bit acc_now;
    int stalls, first, last, errs;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: single ADD, three-cycle latency
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 4'd3;
    in_b      = 4'd5;
    in_op     = 2'b00;
    @(negedge clk);
    check("t1_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat3", 32'(out_valid), 32'd1);
    check("t1_result", 32'(out_result), 32'h08);
    check("t1_ovf", 32'(out_ovf), 32'd0);
    check("t1_tag", 32'(out_tag), 32'd0);
    drain();

    // 2: one of each opcode back to back
    do_reset();
    send(4'd1, 4'd2, 2'b01);
    send(4'd9, 4'd6, 2'b10);
    send(4'd8, 4'd7, 2'b11);
    send(4'd9, 4'd8, 2'b00);
    drain();
    check("t2_count", 32'(got_q.size()), 32'd4);
    check("t2_r0", 32'(got_q[0].result), 32'hFF);
    check("t2_o0", 32'(got_q[0].ovf), 32'd1);
    check("t2_r1", 32'(got_q[1].result), 32'h36);
    check("t2_o1", 32'(got_q[1].ovf), 32'd0);
    check("t2_r2", 32'(got_q[2].result), 32'h08);
    check("t2_o2", 32'(got_q[2].ovf), 32'd0);
    check("t2_r3", 32'(got_q[3].result), 32'h11);
    check("t2_o3", 32'(got_q[3].ovf), 32'd1);
    for (int i = 0; i < 4; i++) check("t2_tag", 32'(got_q[i].tag), 32'(i));

    // 3: back-pressure fills exactly OUT_DEPTH credits
    do_reset();
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_a      = DW'(pa[0]);
    in_b      = DW'(pb[0]);
    in_op     = 2'b00;
    repeat (12) begin
      @(negedge clk);
      acc_now = in_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        idx++;
        if (idx < 6) begin
          in_a = DW'(pa[idx]);
          in_b = DW'(pb[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    check("t3_accepted", 32'(idx), 32'd4);
    @(negedge clk);
    check("t3_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 4; i < 6; i++) send(DW'(pa[i]), DW'(pb[i]), 2'b00);
    drain();
    check("t3_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("t3_tag", 32'(got_q[i].tag), 32'(i));

    // 4: full-rate stream, no bubbles
    do_reset();
    out_ready = 1'b1;
    stalls    = 0;
    first     = -1;
    last      = -1;
    for (int c = 0; c < 50; c++) begin
      in_valid = (c < 40);
      in_a     = DW'($urandom_range(15));
      in_b     = DW'($urandom_range(15));
      in_op    = 2'($urandom_range(3));
      @(negedge clk);
      if (in_valid && !in_ready) stalls++;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("t4_stalls", 32'(stalls), 32'd0);
    check("t4_span", 32'(last - first + 1), 32'd40);
    check("t4_count", 32'(got_q.size()), 32'd40);
    check("t4_txn", 32'(txn_count), 32'd40);

    // 5: reset with results buffered
    out_ready = 1'b0;
    send(4'd2, 4'd3, 2'b00);
    send(4'd4, 4'd5, 2'b10);
    send(4'd6, 4'd1, 2'b01);
    repeat (4) @(posedge clk);
    #1;
    check("t5_buffered", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_txn", 32'(txn_count), 32'd0);
    reset = 1'b0;
    got_q.delete();
    out_ready = 1'b1;
    send(4'd2, 4'd3, 2'b00);
    drain();
    check("t5_count", 32'(got_q.size()), 32'd1);
    check("t5_tag", 32'(got_q[0].tag), 32'd0);
    check("t5_result", 32'(got_q[0].result), 32'd5);

    // 6: tag wrap over 257 randomised transactions
    do_reset();
    run_stream(257, 80, 75);
    drain();
    check("t6_count", 32'(got_q.size()), 32'd257);
    errs = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i].tag != i % 256) errs++;
    check("t6_tag_seq", 32'(errs), 32'd0);
    check("t6_tag255", 32'(got_q[255].tag), 32'd255);
    check("t6_tag256", 32'(got_q[256].tag), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
